// File: rtl/rfphoenix_dctag_ctl_pkg.sv
// rfphoenix_dctag_ctl_pkg: default data-cache geometry and shared types for the tag store.
package rfphoenix_dctag_ctl_pkg;

    localparam int DC_AWID       = 32;
    localparam int DC_WAYS       = 4;
    localparam int DC_LINES      = 128;
    localparam int DC_LINE_BYTES = 64;

    typedef struct packed {
        int offw;
        int ndxw;
        int wayw;
        int taglsb;
    } dctag_geom_t;

    function automatic dctag_geom_t dctag_geom(input int ways, input int lines, input int line_bytes);
        dctag_geom_t g;
        g.offw   = $clog2(line_bytes);
        g.ndxw   = $clog2(lines);
        g.wayw   = $clog2(ways);
        g.taglsb = g.offw + g.ndxw;
        return g;
    endfunction

    localparam dctag_geom_t DC_GEOM = dctag_geom(DC_WAYS, DC_LINES, DC_LINE_BYTES);

    typedef logic [DC_AWID-DC_GEOM.taglsb-1:0] dctag_t;
    typedef logic [DC_GEOM.wayw-1:0] dc_way_t;
    typedef enum logic {IDLE, SWEEP} dctag_state_e;

endpackage

// File: rtl/rfphoenix_dctag_ram.sv
// rfphoenix_dctag_ram: WAYS x LINES tag RAM, one write port, a registered lookup read port
// and a combinational invalidate read port.
module rfphoenix_dctag_ram #(
    parameter int WAYS  = 4,
    parameter int LINES = 128,
    parameter int TAGW  = 19
) (
    input  logic                            clk,
    input  logic                            we,
    input  logic [$clog2(WAYS)-1:0]         wr_way,
    input  logic [$clog2(LINES)-1:0]        wr_ndx,
    input  logic [TAGW-1:0]                 wr_tag,
    input  logic                            re,
    input  logic [$clog2(LINES)-1:0]        rd_ndx,
    output logic [WAYS-1:0][TAGW-1:0]       rd_tag,
    input  logic [$clog2(LINES)-1:0]        inv_ndx,
    output logic [WAYS-1:0][TAGW-1:0]       inv_tag
);

    logic [TAGW-1:0] mem [WAYS][LINES];

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_way][wr_ndx] <= wr_tag;
    end

    // Lookup read returns the contents from before a same-cycle write.
    always_ff @(posedge clk) begin
        if (re)
            for (int w = 0; w < WAYS; w++)
                rd_tag[w] <= mem[w][rd_ndx];
    end

    always_comb begin
        for (int w = 0; w < WAYS; w++)
            inv_tag[w] = mem[w][inv_ndx];
    end

endmodule

// File: rtl/rfphoenix_dctag_ctl.sv
// rfphoenix_dctag_ctl: data-cache tag store with hit detection, valid bits,
// round-robin victim selection and an invalidate sweep.
module rfphoenix_dctag_ctl
    import rfphoenix_dctag_ctl_pkg::*;
#(
    parameter int AWID       = DC_AWID,
    parameter int WAYS       = DC_WAYS,
    parameter int LINES      = DC_LINES,
    parameter int LINE_BYTES = DC_LINE_BYTES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    lookup_v,
    input  logic [AWID-1:0]         lookup_adr,
    output logic                    hit_v,
    output logic                    hit,
    output logic [$clog2(WAYS)-1:0] hit_way,
    output logic [WAYS-1:0]         hit_vec,
    output logic [$clog2(WAYS)-1:0] victim_way,
    input  logic                    wr,
    input  logic [AWID-1:0]         wr_adr,
    input  logic [$clog2(WAYS)-1:0] wr_way,
    input  logic                    inv_line,
    input  logic [AWID-1:0]         inv_adr,
    input  logic                    inv_all,
    output logic                    busy
);

    localparam dctag_geom_t G = dctag_geom(WAYS, LINES, LINE_BYTES);
    localparam int OFFW   = G.offw;
    localparam int NDXW   = G.ndxw;
    localparam int WAYW   = G.wayw;
    localparam int TAGLSB = G.taglsb;
    localparam int TAGW   = AWID - TAGLSB;

    dctag_state_e                 state;
    logic [NDXW-1:0]              cnt;
    logic [LINES-1:0][WAYS-1:0]   valid;
    logic [LINES-1:0][WAYW-1:0]   ptr;
    logic [TAGW-1:0]              lk_tag;
    logic [WAYS-1:0]              lk_valid;
    logic [WAYW-1:0]              lk_ptr;
    logic [WAYS-1:0][TAGW-1:0]    rd_tag;
    logic [WAYS-1:0][TAGW-1:0]    inv_tag;
    logic [WAYS-1:0]              inv_hit;
    logic [NDXW-1:0]              lk_ndx;
    logic [NDXW-1:0]              wr_ndx;
    logic [NDXW-1:0]              inv_ndx;
    logic                         lk_go;
    logic                         wr_go;
    logic                         inv_go;
    logic                         unused_ok;

    assign busy      = state == SWEEP;
    assign lk_go     = lookup_v & ~busy;
    assign wr_go     = wr & ~busy;
    assign inv_go    = inv_line & ~busy;
    assign lk_ndx    = lookup_adr[TAGLSB-1:OFFW];
    assign wr_ndx    = wr_adr[TAGLSB-1:OFFW];
    assign inv_ndx   = inv_adr[TAGLSB-1:OFFW];
    assign unused_ok = ^{lookup_adr[OFFW-1:0], wr_adr[OFFW-1:0], inv_adr[OFFW-1:0]};

    rfphoenix_dctag_ram #(
        .WAYS  (WAYS),
        .LINES (LINES),
        .TAGW  (TAGW)
    ) u_ram (
        .clk     (clk),
        .we      (wr_go),
        .wr_way  (wr_way),
        .wr_ndx  (wr_ndx),
        .wr_tag  (wr_adr[AWID-1:TAGLSB]),
        .re      (lk_go),
        .rd_ndx  (lk_ndx),
        .rd_tag  (rd_tag),
        .inv_ndx (inv_ndx),
        .inv_tag (inv_tag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SWEEP;
            cnt      <= '0;
            hit_v    <= 1'b0;
            lk_valid <= '0;
            lk_ptr   <= '0;
            ptr      <= '0;
        end else begin
            hit_v <= lk_go;
            if (lk_go) begin
                lk_tag   <= lookup_adr[AWID-1:TAGLSB];
                lk_valid <= valid[lk_ndx];
                lk_ptr   <= ptr[lk_ndx];
            end
            if (inv_all) begin
                state <= SWEEP;
                cnt   <= '0;
            end else if (state == SWEEP) begin
                valid[cnt] <= '0;
                cnt        <= cnt + 1'b1;
                if (cnt == NDXW'(LINES - 1))
                    state <= IDLE;
            end
            if (wr_go) begin
                valid[wr_ndx][wr_way] <= 1'b1;
                if (wr_way == ptr[wr_ndx])
                    ptr[wr_ndx] <= ptr[wr_ndx] + 1'b1;
            end
            // Placed after the fill so a same-line invalidate wins.
            if (inv_go)
                for (int w = 0; w < WAYS; w++)
                    if (inv_hit[w])
                        valid[inv_ndx][w] <= 1'b0;
        end
    end

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = lk_valid[w] & (rd_tag[w] == lk_tag);
            inv_hit[w] = inv_tag[w] == inv_adr[AWID-1:TAGLSB];
        end
    end

    assign hit = |hit_vec;

    always_comb begin
        hit_way    = '0;
        victim_way = lk_ptr;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_way    = hit_vec[w] ? WAYW'(w) : hit_way;
            victim_way = !lk_valid[w] ? WAYW'(w) : victim_way;
        end
    end

endmodule

// File: tb/tb_rfphoenix_dctag_ctl.sv
// tb_rfphoenix_dctag_ctl: table-driven bench with a lookup scoreboard for the data-cache tag store.
module tb_rfphoenix_dctag_ctl;

    typedef enum {OP_WR, OP_LK, OP_LKWR, OP_INV, OP_INVWR} op_e;

    typedef struct {
        op_e         op;
        logic [31:0] adr;
        logic [31:0] wadr;
        logic [1:0]  way;
        logic        eh;
        logic [1:0]  ew;
        logic [3:0]  ev;
        logic [1:0]  evic;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lookup_v = 1'b0;
    logic [31:0] lookup_adr = '0;
    logic        hit_v;
    logic        hit;
    logic [1:0]  hit_way;
    logic [3:0]  hit_vec;
    logic [1:0]  victim_way;
    logic        wr = 1'b0;
    logic [31:0] wr_adr = '0;
    logic [1:0]  wr_way = '0;
    logic        inv_line = 1'b0;
    logic [31:0] inv_adr = '0;
    logic        inv_all = 1'b0;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t tv[$];

    rfphoenix_dctag_ctl dut (
        .clk        (clk),
        .rst        (rst),
        .lookup_v   (lookup_v),
        .lookup_adr (lookup_adr),
        .hit_v      (hit_v),
        .hit        (hit),
        .hit_way    (hit_way),
        .hit_vec    (hit_vec),
        .victim_way (victim_way),
        .wr         (wr),
        .wr_adr     (wr_adr),
        .wr_way     (wr_way),
        .inv_line   (inv_line),
        .inv_adr    (inv_adr),
        .inv_all    (inv_all),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Every edge: a queued lookup must show its result now, otherwise hit_v must be low.
    task automatic tick();
        vec_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0)
            chk("idle_hit_v", 32'(hit_v), 0);
        else begin
            e = sb.pop_front();
            chk($sformatf("hit_v@%h", e.adr), 32'(hit_v), 1);
            chk($sformatf("hit@%h", e.adr), 32'(hit), 32'(e.eh));
            chk($sformatf("hit_way@%h", e.adr), 32'(hit_way), 32'(e.ew));
            chk($sformatf("hit_vec@%h", e.adr), 32'(hit_vec), 32'(e.ev));
            chk($sformatf("victim@%h", e.adr), 32'(victim_way), 32'(e.evic));
        end
    endtask

    function automatic vec_t mk(op_e op, logic [31:0] adr, logic [31:0] wadr, logic [1:0] way,
                                logic eh, logic [1:0] ew, logic [3:0] ev, logic [1:0] evic);
        vec_t v;
        v.op = op; v.adr = adr; v.wadr = wadr; v.way = way;
        v.eh = eh; v.ew = ew; v.ev = ev; v.evic = evic;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        logic lk, w, iv;
        lk = v.op == OP_LK || v.op == OP_LKWR;
        w  = v.op == OP_WR || v.op == OP_LKWR || v.op == OP_INVWR;
        iv = v.op == OP_INV || v.op == OP_INVWR;
        lookup_v = lk; lookup_adr = v.adr;
        wr = w; wr_adr = v.wadr; wr_way = v.way;
        inv_line = iv; inv_adr = v.adr;
        if (lk)
            sb.push_back(v);
        tick();
        lookup_v = 1'b0; wr = 1'b0; inv_line = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        // Set 0x0D lives at adr[12:6]; tags are adr[31:13].
        tv.push_back(mk(OP_WR,    32'h0001_2340, 32'h0001_2340, 2, 0, 0, 4'b0000, 0));
        tv.push_back(mk(OP_LK,    32'h0001_2340, 0,             0, 1, 2, 4'b0100, 0));
        tv.push_back(mk(OP_LK,    32'h0002_2340, 0,             0, 0, 0, 4'b0000, 0));
        tv.push_back(mk(OP_WR,    0,             32'h0004_0340, 0, 0, 0, 4'b0000, 0));
        tv.push_back(mk(OP_WR,    0,             32'h0004_2340, 1, 0, 0, 4'b0000, 0));
        tv.push_back(mk(OP_WR,    0,             32'h0004_4340, 2, 0, 0, 4'b0000, 0));
        tv.push_back(mk(OP_WR,    0,             32'h0004_6340, 3, 0, 0, 4'b0000, 0));
        tv.push_back(mk(OP_LK,    32'h0004_4340, 0,             0, 1, 2, 4'b0100, 0));
        tv.push_back(mk(OP_WR,    0,             32'h0004_8340, 0, 0, 0, 4'b0000, 0));
        tv.push_back(mk(OP_LK,    32'h0004_8340, 0,             0, 1, 0, 4'b0001, 1));
        tv.push_back(mk(OP_WR,    0,             32'h0004_A340, 1, 0, 0, 4'b0000, 0));
        tv.push_back(mk(OP_WR,    0,             32'h0004_C340, 2, 0, 0, 4'b0000, 0));
        tv.push_back(mk(OP_LK,    32'h0004_C340, 0,             0, 1, 2, 4'b0100, 3));
        tv.push_back(mk(OP_WR,    0,             32'h0004_E340, 3, 0, 0, 4'b0000, 0));
        tv.push_back(mk(OP_LK,    32'h0004_E340, 0,             0, 1, 3, 4'b1000, 0));
        tv.push_back(mk(OP_WR,    0,             32'h0004_E340, 1, 0, 0, 4'b0000, 0));
        tv.push_back(mk(OP_LK,    32'h0004_E340, 0,             0, 1, 1, 4'b1010, 0));
        tv.push_back(mk(OP_LK,    32'h0004_0340, 0,             0, 0, 0, 4'b0000, 0));
        tv.push_back(mk(OP_LKWR,  32'h0006_0880, 32'h0006_0880, 0, 0, 0, 4'b0000, 0));
        tv.push_back(mk(OP_LK,    32'h0006_0880, 0,             0, 1, 0, 4'b0001, 1));
        tv.push_back(mk(OP_WR,    0,             32'h0006_2880, 1, 0, 0, 4'b0000, 0));
        tv.push_back(mk(OP_WR,    0,             32'h0006_4880, 2, 0, 0, 4'b0000, 0));
        tv.push_back(mk(OP_WR,    0,             32'h0006_6880, 3, 0, 0, 4'b0000, 0));
        tv.push_back(mk(OP_LK,    32'h0006_6880, 0,             0, 1, 3, 4'b1000, 0));
        tv.push_back(mk(OP_INVWR, 32'h0006_2880, 32'h0006_2880, 1, 0, 0, 4'b0000, 0));
        tv.push_back(mk(OP_LK,    32'h0006_2880, 0,             0, 0, 0, 4'b0000, 1));
        tv.push_back(mk(OP_INV,   32'h0004_E340, 0,             0, 0, 0, 4'b0000, 0));
        tv.push_back(mk(OP_LK,    32'h0004_E340, 0,             0, 0, 0, 4'b0000, 1));
        tv.push_back(mk(OP_INVWR, 32'h0004_8340, 32'h0006_2880, 1, 0, 0, 4'b0000, 0));
        tv.push_back(mk(OP_LK,    32'h0004_8340, 0,             0, 0, 0, 4'b0000, 0));
        tv.push_back(mk(OP_LK,    32'h0006_2880, 0,             0, 1, 1, 4'b0010, 0));
        tv.push_back(mk(OP_LK,    32'h0004_C340, 0,             0, 1, 2, 4'b0100, 0));

        repeat (3) tick();
        chk("rst_busy", 32'(busy), 1);
        chk("rst_hit_v", 32'(hit_v), 0);
        chk("rst_hit", 32'(hit), 0);
        chk("rst_hit_way", 32'(hit_way), 0);
        chk("rst_hit_vec", 32'(hit_vec), 0);
        chk("rst_victim", 32'(victim_way), 0);

        // Requests held during the power-on sweep must be ignored.
        rst = 1'b0;
        lookup_v = 1'b1; lookup_adr = 32'h0006_0880;
        wr = 1'b1; wr_adr = 32'h0006_0880; wr_way = 0;
        count_busy(n);
        lookup_v = 1'b0; wr = 1'b0;
        chk("reset_sweep_len", n, 128);

        for (int i = 0; i < tv.size(); i++)
            apply(tv[i]);

        // inv_all accepted together with a lookup that still sees the old state.
        lookup_v = 1'b1; lookup_adr = 32'h0006_2880; inv_all = 1'b1;
        sb.push_back(mk(OP_LK, 32'h0006_2880, 0, 0, 1, 1, 4'b0010, 0));
        tick();
        inv_all = 1'b0;
        wr = 1'b1; wr_adr = 32'h0006_0880; wr_way = 0;
        inv_line = 1'b1; inv_adr = 32'h0001_2340;
        count_busy(n);
        lookup_v = 1'b0; wr = 1'b0; inv_line = 1'b0;
        chk("inv_all_sweep_len", n, 128);
        apply(mk(OP_LK, 32'h0006_2880, 0, 0, 0, 0, 4'b0000, 0));
        apply(mk(OP_LK, 32'h0006_0880, 0, 0, 0, 0, 4'b0000, 0));
        apply(mk(OP_LK, 32'h0004_C340, 0, 0, 0, 0, 4'b0000, 0));

        inv_all = 1'b1;
        tick();
        inv_all = 1'b0;
        repeat (50) tick();
        chk("mid_sweep_busy", 32'(busy), 1);
        inv_all = 1'b1;
        tick();
        inv_all = 1'b0;
        count_busy(n);
        chk("restart_sweep_len", n, 128);

        apply(mk(OP_WR, 0, 32'h0001_2340, 3, 0, 0, 4'b0000, 0));
        inv_all = 1'b1;
        tick();
        inv_all = 1'b0;
        repeat (30) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy(n);
        chk("rst_mid_sweep_len", n, 128);
        apply(mk(OP_LK, 32'h0001_2340, 0, 0, 0, 0, 4'b0000, 0));

        tick();
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rfphoenix_dctag_ctl.md
Name: rfphoenix_dctag_ctl

Overview:
Parametrised data-cache tag store with integrated hit detection, per-set valid bits, victim selection and an invalidate sweep FSM.
It sits between the data-cache address stage and the data RAM / miss handler. It replaces the bare tag array, which had no valid state, no hit compare and a fixed geometry.
The lookup is pipelined, with one-cycle latency from address to hit and way result.

Parameters:
AWID, 32, address width in bits.
WAYS, 4, associativity; must be a power of 2 and at least 2.
LINES, 128, sets per way; must be a power of 2.
LINE_BYTES, 64, bytes per cache line; must be a power of 2.
Derived: OFFW = $clog2(LINE_BYTES), NDXW = $clog2(LINES), WAYW = $clog2(WAYS), TAGLSB = OFFW + NDXW. The tag is adr[AWID-1:TAGLSB].

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
lookup_v  in  1  lookup request.
lookup_adr  in  AWID  lookup address.
hit_v  out  1  result valid, one cycle after an accepted lookup_v.
hit  out  1  some valid way's tag matches.
hit_way  out  WAYW  index of the lowest matching way; 0 when no hit.
hit_vec  out  WAYS  per-way match bits.
victim_way  out  WAYW  way to refill for the set of the last accepted lookup.
wr  in  1  tag fill: write the tag and set the valid bit.
wr_adr  in  AWID  fill address.
wr_way  in  WAYW  way to fill.
inv_line  in  1  invalidate matching line(s) in the set of inv_adr.
inv_adr  in  AWID  invalidate address.
inv_all  in  1  start a full invalidate sweep.
busy  out  1  sweep in progress; requests are ignored.

Behaviour:
- Storage:
  - Tags are held in a synchronous-read RAM, WAYS x LINES x (AWID-TAGLSB) bits.
  - Valid bits and per-set round-robin pointers (WAYW bits each) are held in flops.
  - Tags have no reset; valid bits clear only through the sweep.
- Reset:
  - rst forces the FSM to SWEEP with sweep counter 0.
  - Outputs during reset: busy=1, hit_v=0, hit=0, hit_way=0, hit_vec=0, victim_way=0.
  - All round-robin pointers reset to 0.
- FSM, IDLE and SWEEP:
  - SWEEP clears the valid bits of set cnt in all ways, one set per cycle.
  - cnt increments each cycle; after set LINES-1 the FSM enters IDLE. A sweep therefore takes exactly LINES cycles.
  - busy=1 in SWEEP.
  - inv_all while in IDLE enters SWEEP on the next cycle with cnt=0.
  - inv_all while already in SWEEP restarts cnt at 0.
  - rst mid-sweep restarts the sweep.
- While busy:
  - lookup_v, wr and inv_line are ignored; no state changes result from them.
  - hit_v=0 the following cycle.
- Lookup:
  - lookup_v is accepted in cycle N.
  - In cycle N+1: hit_v=1, hit_vec[w] = valid[w][ndx] & (tag[w] == lookup tag), hit = |hit_vec, hit_way = lowest set bit of hit_vec.
  - victim_way in cycle N+1 = the lowest way with valid=0 in that set; if all ways are valid, the set's round-robin pointer.
  - Results hold until the next accepted lookup; hit_v is a one-cycle pulse.
- Read-before-write:
  - A lookup in cycle N sees tag and valid state from before any wr or inv_line in cycle N.
  - A lookup in cycle N+1 sees that update.
- Fill (wr):
  - Writes the tag and sets valid[wr_way][ndx].
  - If wr_way equals the set's pointer, the pointer advances by 1 modulo WAYS, wrapping from WAYS-1 to 0.
- Invalidate line (inv_line):
  - Compares the tag of inv_adr against all ways of the set and clears valid on every matching way.
  - The tag compare is combinational against the tag RAM. The tag RAM has two read ports, one for lookup and one for invalidate.
- Simultaneous wr and inv_line:
  - Same set and same way: inv_line wins and the line ends invalid.
  - Different sets: both apply.
- Duplicate tags from a miss-handler bug:
  - hit_way reports the lowest matching way.
  - inv_line clears all matching ways.

Decomposition:
- Shared package (rfPhoenix cache package): a dctag geometry struct or localparams (OFFW, NDXW, TAGLSB); typedef dctag_t for the tag field; typedef dc_way_t as a logic[WAYW-1:0] way index.
- One sub-module, rfphoenix_dctag_ram: a parametrised WAYS x LINES tag RAM with one write port and two read ports, inferred as block RAM.
- The FSM, valid bits, compare logic and victim logic live in the top module.

Test Plan:
1. Reset, then a lookup in cycle 1 -> busy=1 for exactly 128 cycles; the lookup is ignored (hit_v stays 0); busy falls in cycle 128.
2. wr adr=0x0001_2340, way=2; then a lookup of 0x0001_2340 -> hit=1, hit_way=2, hit_vec=4'b0100. Lookup of 0x0002_2340 (same set, different tag) -> hit=0.
3. Fill ways 0..3 of set 0x0D and then look up set 0x0D -> victim_way=0. Fill way 0 again -> pointer advances; next lookup gives victim_way=1. Continue to check wrap from 3 to 0.
4. A lookup and wr to the same address in the same cycle -> hit=0. A lookup of the same address the next cycle -> hit=1.
5. Valid line in way 1; inv_line and wr to that line/way in the same cycle -> the following lookup gives hit=0 and victim_way=1.
6. Fill several sets, pulse inv_all, keep lookup_v high -> busy for 128 cycles with no hit_v; afterwards all lookups miss and victim_way=0.
